// File: rtl/sramdp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sramdp_pkg
// Purpose  : Shared types and constants for the sramdp_ctrl dual-port memory
//            controller: controller FSM state encoding and collision counter
//            width / saturation value.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package sramdp_pkg;

  // Controller states: INIT runs the clear sweep, RUN serves requests.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int                    COLL_CNT_W   = 16;
  localparam logic [COLL_CNT_W-1:0] COLL_CNT_MAX = 16'hFFFF;

endpackage : sramdp_pkg
`default_nettype wire

// File: rtl/sramdp_array.sv
`default_nettype none
// ============================================================================
// Module   : sramdp_array
// Purpose  : Behavioural 2^AW x DW memory with one per-bit masked write port
//            and one registered read port. Contents are never reset; only the
//            read output register is cleared by rst.
// Ports    : clk    in   clock
//            rst    in   synchronous active-high reset (read register only)
//            we     in   write enable
//            waddr  in   write address
//            wdata  in   write data
//            wmask  in   per-bit write enable, 1 = write bit
//            re     in   read enable
//            raddr  in   read address
//            rdata  out  read data, valid the cycle after re, held otherwise
// Revision : 1.0  initial release
// ============================================================================
module sramdp_array #(
  parameter int AW = 10,
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] wmask,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  // Masked write: bits with wmask=0 keep their stored value.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= (r_mem[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  // Read-before-write on an address collision; the controller patches in the
  // written bits itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= r_mem[raddr];
    end
  end

endmodule : sramdp_array
`default_nettype wire

// File: rtl/sramdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sramdp_ctrl
// Purpose  : Single-clock 1-write/1-read memory controller with ready/valid
//            request acceptance, post-reset and on-demand clear sweep, per-bit
//            masked writes, write-first same-address forwarding and a
//            saturating collision counter.
// Options  : define SRAMDP_OUTREG_EN to add an output register stage
//            (read latency 2 instead of 1).
// Ports    : CLK        in   clock
//            RST        in   synchronous active-high reset
//            ready      out  requests are accepted this cycle
//            init_done  out  clear sweep complete (level)
//            clr_req    in   start a clear sweep (honoured in RUN only)
//            wr_req     in   write request
//            wr_addr    in   write address
//            wr_data    in   write data
//            wr_mask    in   per-bit write enable
//            rd_req     in   read request
//            rd_addr    in   read address
//            rd_valid   out  one-cycle pulse per accepted read
//            rd_data    out  read data, held while rd_valid=0
//            coll_cnt   out  saturating same-address write/read count
// Revision : 1.0  initial release
// ============================================================================
module sramdp_ctrl
  import sramdp_pkg::*;
#(
  parameter int               WORDSWD    = 10,
  parameter int               BITS       = 19,
  parameter bit               CLR_ON_RST = 1'b1,
  parameter logic [BITS-1:0]  INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  ready,
  output logic                  init_done,
  input  logic                  clr_req,
  input  logic                  wr_req,
  input  logic [WORDSWD-1:0]    wr_addr,
  input  logic [BITS-1:0]       wr_data,
  input  logic [BITS-1:0]       wr_mask,
  input  logic                  rd_req,
  input  logic [WORDSWD-1:0]    rd_addr,
  output logic                  rd_valid,
  output logic [BITS-1:0]       rd_data,
  output logic [COLL_CNT_W-1:0] coll_cnt
);

  localparam logic [WORDSWD-1:0]    C_LAST_ADDR = '1;
  localparam logic [WORDSWD-1:0]    C_ADDR_ONE  = {{(WORDSWD-1){1'b0}}, 1'b1};
  localparam logic [COLL_CNT_W-1:0] C_CNT_ONE   = {{(COLL_CNT_W-1){1'b0}}, 1'b1};
  localparam state_t                C_RST_STATE = CLR_ON_RST ? ST_INIT : ST_RUN;

  state_t                  r_state;
  logic [WORDSWD-1:0]      r_clr_addr;
  logic                    r_ready;
  logic                    r_init_done;
  logic                    r_rd_valid;
  logic [BITS-1:0]         r_fwd_data;
  logic [BITS-1:0]         r_fwd_mask;
  logic [COLL_CNT_W-1:0]   r_coll_cnt;

  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_coll;
  logic                    w_arr_we;
  logic [WORDSWD-1:0]      w_arr_waddr;
  logic [BITS-1:0]         w_arr_wdata;
  logic [BITS-1:0]         w_arr_wmask;
  logic [BITS-1:0]         w_arr_rdata;
  logic [BITS-1:0]         w_rd_word;

  assign w_wr_acc = wr_req & r_ready;
  assign w_rd_acc = rd_req & r_ready;
  assign w_coll   = w_wr_acc & w_rd_acc & (wr_addr == rd_addr);

  // --------------------------------------------------------------------------
  // Control FSM. ready/init_done are registered alongside the state so they
  // rise the cycle after the last sweep write and fall the cycle after clr_req.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= C_RST_STATE;
      r_clr_addr  <= '0;
      r_ready     <= !CLR_ON_RST;
      r_init_done <= !CLR_ON_RST;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_clr_addr == C_LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_clr_addr  <= '0;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end else begin
            r_clr_addr  <= r_clr_addr + C_ADDR_ONE;
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            r_state     <= ST_INIT;
            r_clr_addr  <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
          end
        end
        default: begin
          r_state     <= C_RST_STATE;
          r_clr_addr  <= '0;
          r_ready     <= 1'b0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Sweep owns the write port while in INIT; requests are never accepted then.
  always_comb begin
    w_arr_we    = w_wr_acc;
    w_arr_waddr = wr_addr;
    w_arr_wdata = wr_data;
    w_arr_wmask = wr_mask;
    if (r_state == ST_INIT) begin
      w_arr_we    = 1'b1;
      w_arr_waddr = r_clr_addr;
      w_arr_wdata = INIT_VAL;
      w_arr_wmask = '1;
    end
  end

  sramdp_array #(
    .AW (WORDSWD),
    .DW (BITS)
  ) u_array (
    .clk   (CLK),
    .rst   (RST),
    .we    (w_arr_we),
    .waddr (w_arr_waddr),
    .wdata (w_arr_wdata),
    .wmask (w_arr_wmask),
    .re    (w_rd_acc),
    .raddr (rd_addr),
    .rdata (w_arr_rdata)
  );

  // --------------------------------------------------------------------------
  // Write-first forwarding. The array returns pre-write data on a collision,
  // so the written bits are captured with the read and merged afterwards.
  // A non-colliding read captures a zero mask, passing array data straight
  // through. All terms only change on an accepted read, so the merged word
  // holds its value between reads.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_valid <= 1'b0;
      r_fwd_data <= '0;
      r_fwd_mask <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_fwd_data <= wr_data;
        r_fwd_mask <= w_coll ? wr_mask : '0;
      end
    end
  end

  assign w_rd_word = (w_arr_rdata & ~r_fwd_mask) | (r_fwd_data & r_fwd_mask);

  // Collision counter survives clr_req; only RST clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_coll_cnt <= '0;
    end else if (w_coll && (r_coll_cnt != COLL_CNT_MAX)) begin
      r_coll_cnt <= r_coll_cnt + C_CNT_ONE;
    end
  end

`ifdef SRAMDP_OUTREG_EN
  logic            r_out_valid;
  logic [BITS-1:0] r_out_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= r_rd_valid;
      if (r_rd_valid) begin
        r_out_data <= w_rd_word;
      end
    end
  end

  assign rd_valid = r_out_valid;
  assign rd_data  = r_out_data;
`else
  assign rd_valid = r_rd_valid;
  assign rd_data  = w_rd_word;
`endif

  assign ready     = r_ready;
  assign init_done = r_init_done;
  assign coll_cnt  = r_coll_cnt;

endmodule : sramdp_ctrl
`default_nettype wire

// File: tb/tb_sramdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sramdp_ctrl
// Purpose  : Self-checking bench for sramdp_ctrl (WORDSWD=4, BITS=8,
//            CLR_ON_RST=1, INIT_VAL=8'hA5). Every cycle is compared against a
//            request-level memory model; directed vectors and sequences add
//            hand-derived expectations. Honours SRAMDP_OUTREG_EN for latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_sramdp_ctrl;

  localparam int         AW    = 4;
  localparam int         DW    = 8;
  localparam int         DEPTH = 16;
  localparam logic [7:0] IV    = 8'hA5;
`ifdef SRAMDP_OUTREG_EN
  localparam int         LAT   = 2;
`else
  localparam int         LAT   = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          clr_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] wr_mask = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          ready;
  logic          init_done;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [15:0]   coll_cnt;

  always #5 CLK = ~CLK;

  sramdp_ctrl #(
    .WORDSWD    (AW),
    .BITS       (DW),
    .CLR_ON_RST (1'b1),
    .INIT_VAL   (IV)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ready     (ready),
    .init_done (init_done),
    .clr_req   (clr_req),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .coll_cnt  (coll_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- request-level reference model ----------------
  logic [7:0] m_mem [DEPTH];
  bit         m_ready     = 1'b0;
  bit         m_init_done = 1'b0;
  int         m_sweep     = 0;
  int         m_coll      = 0;
  bit         m_pv [LAT];
  logic [7:0] m_pd [LAT];
  bit         m_valid     = 1'b0;
  logic [7:0] m_data      = 8'h00;

  task automatic model_step(input bit rst_i, input bit clr_i, input bit wr_i,
                            input logic [3:0] wa_i, input logic [7:0] wd_i,
                            input logic [7:0] wm_i, input bit rd_i,
                            input logic [3:0] ra_i);
    bit         nv;
    logic [7:0] nd;
    nv = 1'b0;
    nd = 8'h00;
    if (rst_i) begin
      m_ready = 1'b0; m_init_done = 1'b0; m_sweep = 0; m_coll = 0;
      for (int i = 0; i < LAT; i++) begin m_pv[i] = 1'b0; m_pd[i] = 8'h00; end
      m_valid = 1'b0; m_data = 8'h00;
      return;
    end
    if (!m_ready) begin
      // Clear sweep: one word per cycle, ready once the last word is written.
      m_mem[m_sweep] = IV;
      m_sweep++;
      if (m_sweep == DEPTH) begin
        m_ready = 1'b1; m_init_done = 1'b1; m_sweep = 0;
      end
    end else begin
      if (rd_i) begin
        nv = 1'b1;
        nd = m_mem[ra_i];
        if (wr_i && wa_i == ra_i) begin
          nd = (nd & ~wm_i) | (wd_i & wm_i);
          if (m_coll < 65535) m_coll++;
        end
      end
      if (wr_i) m_mem[wa_i] = (m_mem[wa_i] & ~wm_i) | (wd_i & wm_i);
      if (clr_i) begin
        m_ready = 1'b0; m_init_done = 1'b0; m_sweep = 0;
      end
    end
    for (int i = LAT - 1; i > 0; i--) begin m_pv[i] = m_pv[i-1]; m_pd[i] = m_pd[i-1]; end
    m_pv[0] = nv;
    m_pd[0] = nd;
    m_valid = m_pv[LAT-1];
    if (m_valid) m_data = m_pd[LAT-1];
  endtask

  // One clock: drive, clock, sample 1 ns after the edge, compare to model.
  task automatic cycle(input bit rst_i, input bit clr_i, input bit wr_i,
                       input logic [3:0] wa_i, input logic [7:0] wd_i,
                       input logic [7:0] wm_i, input bit rd_i,
                       input logic [3:0] ra_i);
    RST = rst_i; clr_req = clr_i; wr_req = wr_i; wr_addr = wa_i;
    wr_data = wd_i; wr_mask = wm_i; rd_req = rd_i; rd_addr = ra_i;
    @(posedge CLK);
    #1;
    model_step(rst_i, clr_i, wr_i, wa_i, wd_i, wm_i, rd_i, ra_i);
    chk("model_ready",     ready,     m_ready);
    chk("model_init_done", init_done, m_init_done);
    chk("model_rd_valid",  rd_valid,  m_valid);
    chk("model_rd_data",   rd_data,   m_data);
    chk("model_coll_cnt",  coll_cnt,  m_coll[15:0]);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         wr;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [7:0] wm;
    bit         rd;
    logic [3:0] ra;
    logic [7:0] exp_d;
    logic [15:0] exp_c;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n;
    tbl[0]  = '{1'b1, 4'd3,  8'h3C, 8'hFF, 1'b0, 4'd0,  8'h00, 16'd0};
    tbl[1]  = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b1, 4'd3,  8'h3C, 16'd0};
    tbl[2]  = '{1'b1, 4'd3,  8'hF0, 8'h0F, 1'b0, 4'd0,  8'h00, 16'd0};
    tbl[3]  = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b1, 4'd3,  8'h30, 16'd0};
    tbl[4]  = '{1'b1, 4'd5,  8'h11, 8'hFF, 1'b0, 4'd0,  8'h00, 16'd0};
    tbl[5]  = '{1'b1, 4'd5,  8'hEE, 8'hF0, 1'b1, 4'd5,  8'hE1, 16'd1};
    tbl[6]  = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b1, 4'd5,  8'hE1, 16'd1};
    tbl[7]  = '{1'b1, 4'd6,  8'h77, 8'hFF, 1'b1, 4'd3,  8'h30, 16'd1};
    tbl[8]  = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b1, 4'd6,  8'h77, 16'd1};
    tbl[9]  = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b1, 4'd0,  8'hA5, 16'd1};
    tbl[10] = '{1'b1, 4'd5,  8'h00, 8'hFF, 1'b1, 4'd5,  8'h00, 16'd2};
    tbl[11] = '{1'b1, 4'd12, 8'hFF, 8'h00, 1'b1, 4'd12, 8'hA5, 16'd3};
    tbl[12] = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b1, 4'd15, 8'hA5, 16'd3};

    // ---- reset state ----
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0);
    chk("rst_ready",     ready,     1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_rd_valid",  rd_valid,  1'b0);
    chk("rst_rd_data",   rd_data,   8'h00);
    chk("rst_coll_cnt",  coll_cnt,  16'h0000);

    // ---- post-reset sweep: requests held high are refused ----
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      cycle(1'b0, 1'b0, 1'b1, 4'(n), 8'h5A, 8'hFF, 1'b1, 4'(n));
      chk("sweep_no_rd_valid", rd_valid, 1'b0);
      n++;
    end
    chk("sweep_len_after_rst", n, 16);
    chk("init_done_after_sweep", init_done, 1'b1);

    // Back-to-back reads of every address.
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 4'(a));
    repeat (LAT) idle();
    chk("sweep_last_rd_data", rd_data, 8'hA5);

    // ---- directed table ----
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 1'b0, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].wm, tbl[i].rd, tbl[i].ra);
      if (tbl[i].rd) begin
        repeat (LAT - 1) idle();
        chk("tbl_rd_valid", rd_valid, 1'b1);
        chk("tbl_rd_data",  rd_data,  tbl[i].exp_d);
        chk("tbl_coll_cnt", coll_cnt, tbl[i].exp_c);
        idle();
        chk("tbl_rd_valid_pulse", rd_valid, 1'b0);
      end
    end

    // ---- clr_req with a same-cycle read, then RST at sweep cycle 7 ----
    cycle(1'b0, 1'b0, 1'b1, 4'd9, 8'h42, 8'hFF, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd9);
    for (int k = 1; k < LAT; k++) cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd1);
    chk("preclr_rd_valid", rd_valid, 1'b1);
    chk("preclr_rd_data",  rd_data,  8'h42);
    for (int k = LAT; k < 8; k++) begin
      cycle(1'b0, (k == 3), 1'b1, 4'(k), 8'h99, 8'hFF, 1'b1, 4'(k));
      chk("clr_sweep_ready",    ready,    1'b0);
      chk("clr_sweep_rd_valid", rd_valid, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2);
      n++;
    end
    chk("sweep_len_restart", n, 16);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd9);
    repeat (LAT - 1) idle();
    chk("cleared_addr9", rd_data, 8'hA5);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      cycle(1'b0, ($urandom_range(0, 59) == 0), 1'($urandom), 4'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
    end

    // ---- drive the collision counter into saturation ----
    n = 0;
    while (m_coll < 65535 && n < 70000) begin
      cycle(1'b0, 1'b0, 1'b1, 4'd2, 8'($urandom), 8'($urandom), 1'b1, 4'd2);
      n++;
    end
    chk("sat_reached_in_budget", (n < 70000), 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 4'd7, 8'h01, 8'hFF, 1'b1, 4'd7);
    chk("coll_saturated", coll_cnt, 16'hFFFF);
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0);
    repeat (16) idle();
    chk("ready_after_clr", ready, 1'b1);
    chk("coll_kept_by_clr", coll_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sramdp_ctrl
`default_nettype wire
